uart_tx_arb: RTL and testbench



---
 rtl/uart_tx_arb.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_arb.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: packet-locked round-robin arbiter sharing the UART TX FIFO
// write port between NREQ byte-stream requesters.
// Optional feature: define UART_ARB_TIMEOUT_EN to release a locked grant whose
// owner has been idle for TIMEOUT cycles (timeout_o pulses on that release).
module uart_tx_arb #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid_i,
  input  logic [8*NREQ-1:0]   req_data_i,
  input  logic [NREQ-1:0]     req_last_i,
  output logic [NREQ-1:0]     req_ready_o,
  output logic                fifo_we_o,
  output logic [7:0]          fifo_wdata_o,
  input  logic                fifo_full_i,
  output logic [NREQ-1:0]     grant_o,
  output logic                busy_o,
  output logic                timeout_o
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SUMW = IDXW + 1;
  localparam int CNTW = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Elaboration-time parameter range guards.
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("uart_tx_arb: NREQ must be in 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 256) begin : g_bad_burst
    $error("uart_tx_arb: MAX_BURST must be in 1..256");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("uart_tx_arb: TIMEOUT must be at least 1");
  end

  state_t            state_q;
  logic [IDXW-1:0]   owner_q;
  logic [IDXW-1:0]   last_grant_q;
  logic [CNTW-1:0]   burst_cnt_q;
  logic [CNTW-1:0]   burst_cnt_d;
  logic [NREQ-1:0]   grant_q;
  logic              busy_q;
  logic              timeout_q;

  logic              pick_found_s;
  logic [IDXW-1:0]   pick_idx_s;
  logic [SUMW-1:0]   cand_sum_s;

  logic              lock_active_s;
  logic              owner_valid_s;
  logic              owner_last_s;
  logic [7:0]        owner_data_s;
  logic [NREQ-1:0]   ready_s;
  logic              we_s;
  logic [7:0]        wdata_s;
  logic              release_s;
  logic              timeout_hit_s;

  // Round-robin search: first valid requester after the last owner, wrapping modulo NREQ.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    cand_sum_s   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_sum_s = {1'b0, last_grant_q} + SUMW'(i);
      if (cand_sum_s >= SUMW'(NREQ)) begin
        cand_sum_s = cand_sum_s - SUMW'(NREQ);
      end else begin
        cand_sum_s = cand_sum_s;
      end
      if (!pick_found_s && req_valid_i[cand_sum_s[IDXW-1:0]]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_sum_s[IDXW-1:0];
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Owner-side handshake: ready/write follow full in the same cycle; reset blocks any transfer.
  always_comb begin
    owner_valid_s = req_valid_i[owner_q];
    owner_last_s  = req_last_i[owner_q];
    owner_data_s  = req_data_i[{owner_q, 3'b000} +: 8];
    lock_active_s = (state_q == ST_LOCK) && !rst;
    ready_s       = '0;
    if (lock_active_s) begin
      ready_s[owner_q] = !fifo_full_i;
    end else begin
      ready_s = '0;
    end
    we_s = lock_active_s && owner_valid_s && !fifo_full_i;
    if (we_s) begin
      wdata_s = owner_data_s;
    end else begin
      wdata_s = 8'h00;
    end
    burst_cnt_d = burst_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
    // Last byte and burst limit on the same transfer collapse into one release.
    release_s = we_s && (owner_last_s || (burst_cnt_q == CNTW'(MAX_BURST - 1)));
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT) + 1;
  logic [TOW-1:0] idle_cnt_q;

  // Idle-timeout detect: owner not valid and FIFO not full on the TIMEOUT-th idle cycle.
  always_comb begin
    timeout_hit_s = lock_active_s && !owner_valid_s && !fifo_full_i &&
                    (idle_cnt_q == TOW'(TIMEOUT - 1));
  end
`else
  // Without the timeout feature a locked grant is held until its packet ends.
  always_comb begin
    timeout_hit_s = 1'b0;
  end
`endif

  // Arbiter FSM: grant on pick, hold through the packet, release on last/burst/timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_grant_q <= IDXW'(NREQ - 1);
      burst_cnt_q  <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      idle_cnt_q   <= '0;
`endif
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          burst_cnt_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
          idle_cnt_q  <= '0;
`endif
          if (pick_found_s) begin
            state_q <= ST_LOCK;
            owner_q <= pick_idx_s;
            grant_q <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        ST_LOCK: begin
          if (release_s || timeout_hit_s) begin
            state_q      <= ST_IDLE;
            last_grant_q <= owner_q;
            burst_cnt_q  <= '0;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= timeout_hit_s;
          end else if (we_s) begin
            burst_cnt_q  <= burst_cnt_d;
          end else begin
            burst_cnt_q  <= burst_cnt_q;
          end
`ifdef UART_ARB_TIMEOUT_EN
          // A full FIFO is back-pressure, not owner idleness: hold the count.
          if (release_s || timeout_hit_s || owner_valid_s) begin
            idle_cnt_q <= '0;
          end else if (!fifo_full_i) begin
            idle_cnt_q <= idle_cnt_q + {{(TOW-1){1'b0}}, 1'b1};
          end else begin
            idle_cnt_q <= idle_cnt_q;
          end
`endif
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = ready_s;
  assign fifo_we_o    = we_s;
  assign fifo_wdata_o = wdata_s;
  assign grant_o      = grant_q;
  assign busy_o       = busy_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: queue-driven requesters, a transaction-level
// arbitration model checked every cycle, and literal expectations for directed cases.
`timescale 1ns/1ps
module tb_uart_tx_arb;
  localparam int NREQ      = 4;
  localparam int MAX_BURST = 16;
  localparam int TIMEOUT   = 8;
  localparam int IW        = $clog2(NREQ);

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid_i, req_last_i, req_ready_o, grant_o;
  logic [8*NREQ-1:0] req_data_i;
  logic              fifo_we_o, fifo_full_i, busy_o, timeout_o;
  logic [7:0]        fifo_wdata_o;

  always #5 clk = ~clk;

  uart_tx_arb #(.NREQ(NREQ), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .fifo_we_o(fifo_we_o), .fifo_wdata_o(fifo_wdata_o),
    .fifo_full_i(fifo_full_i), .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] src_q [NREQ][$];      // {last, byte} per requester
  int pushed_total = 0, written_total = 0, cyc = 0, tpulse_cnt = 0;
  int valid_pct = 100, full_pct = 0;
  bit force_full = 1'b0, rst_drive = 1'b0;
  logic [NREQ-1:0] gate_mask = '0;
  // reference model: owner index (-1 when idle), last owner, bytes in grant, idle run
  int m_owner = -1, m_last = NREQ-1, m_cnt = 0, m_idle = 0;
  bit m_tpulse = 1'b0;
  int grant_log[$];
  int wr_log[$];
  int wr_cyc[$];
  logic [NREQ-1:0] prev_grant = '0;
  logic [NREQ-1:0] s_ready, s_grant;
  logic s_we, s_busy, s_timeout;
  logic [7:0] s_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int oh2idx(input logic [NREQ-1:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (oh[IW'(i)]) r = i;
    return r;
  endfunction

  function automatic logic sel_bit(input logic [NREQ-1:0] vec, input int idx);
    logic [NREQ-1:0] sh;
    sh = vec >> idx;
    return sh[0];
  endfunction

  function automatic logic [7:0] sel_byte(input logic [8*NREQ-1:0] vec, input int idx);
    logic [8*NREQ-1:0] sh;
    sh = vec >> (8 * idx);
    return sh[7:0];
  endfunction

  function automatic bit pending();
    bit p;
    p = 1'b0;
    for (int k = 0; k < NREQ; k++) if (src_q[IW'(k)].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic push_pkt(input int k, input int n, input int base, input bit with_last);
    for (int j = 0; j < n; j++)
      src_q[IW'(k)].push_back({(with_last && (j == n - 1)), 8'(base + j)});
    pushed_total += n;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    wr_log.delete();
    wr_cyc.delete();
    tpulse_cnt = 0;
  endtask

  // One clock cycle: drive after the edge, compare at negedge, advance the model.
  task automatic step();
    logic [NREQ-1:0]   v, l;
    logic [8*NREQ-1:0] d;
    logic [7:0]        dd [NREQ];
    logic [8:0]        hd;
    logic              f;
    int                exp_grant, exp_ready, exp_we, exp_wdata, c;
    bit                found;
    v = '0;
    l = '0;
    d = '0;
    for (int k = 0; k < NREQ; k++) begin
      dd[IW'(k)] = 8'($urandom);
      l[IW'(k)]  = 1'($urandom);
      if (src_q[IW'(k)].size() > 0 && !gate_mask[IW'(k)] &&
          int'($urandom_range(99)) < valid_pct) begin
        hd = src_q[IW'(k)][0];
        v[IW'(k)]  = 1'b1;
        dd[IW'(k)] = hd[7:0];
        l[IW'(k)]  = hd[8];
      end
    end
    for (int k = NREQ - 1; k >= 0; k--) d = {d[8*NREQ-9:0], dd[IW'(k)]};
    f = force_full | (int'($urandom_range(99)) < full_pct);
    rst = rst_drive;
    req_valid_i = v;
    req_data_i  = d;
    req_last_i  = l;
    fifo_full_i = f;
    @(negedge clk);
    cyc++;
    s_ready = req_ready_o; s_grant = grant_o; s_we = fifo_we_o;
    s_busy = busy_o; s_timeout = timeout_o; s_wdata = fifo_wdata_o;
    if (fifo_we_o === 1'b1) begin
      written_total++;
      wr_log.push_back((oh2idx(grant_o) << 8) | int'(fifo_wdata_o));
      wr_cyc.push_back(cyc);
    end
    if (timeout_o === 1'b1) tpulse_cnt++;
    if (grant_o != '0 && prev_grant == '0) grant_log.push_back(oh2idx(grant_o));
    prev_grant = grant_o;
    if (rst_drive) begin
      m_owner = -1; m_last = NREQ - 1; m_cnt = 0; m_idle = 0; m_tpulse = 1'b0;
    end else begin
      exp_grant = (m_owner >= 0) ? (1 << m_owner) : 0;
      exp_ready = 0; exp_we = 0; exp_wdata = 0;
      if (m_owner >= 0 && !f) begin
        exp_ready = 1 << m_owner;
        exp_we    = int'(sel_bit(v, m_owner));
        if (exp_we != 0) exp_wdata = int'(sel_byte(d, m_owner));
      end
      check("grant_o", 32'(grant_o), 32'(exp_grant));
      check("busy_o", 32'(busy_o), 32'(m_owner >= 0));
      check("req_ready_o", 32'(req_ready_o), 32'(exp_ready));
      check("fifo_we_o", 32'(fifo_we_o), 32'(exp_we));
      check("fifo_wdata_o", 32'(fifo_wdata_o), 32'(exp_wdata));
      check("timeout_o", 32'(timeout_o), 32'(m_tpulse));
      m_tpulse = 1'b0;
      if (m_owner < 0) begin
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
          c = (m_last + i) % NREQ;
          if (!found && sel_bit(v, c)) begin
            found = 1'b1; m_owner = c; m_cnt = 0; m_idle = 0;
          end
        end
      end else if (exp_we != 0) begin
        void'(src_q[IW'(m_owner)].pop_front());
        m_cnt++;
        m_idle = 0;
        if (sel_bit(l, m_owner) || m_cnt == MAX_BURST) begin
          m_last = m_owner; m_owner = -1;
        end
      end else begin
`ifdef UART_ARB_TIMEOUT_EN
        if (sel_bit(v, m_owner)) m_idle = 0;
        else if (!f) begin
          m_idle++;
          if (m_idle == TIMEOUT) begin
            m_last = m_owner; m_owner = -1; m_tpulse = 1'b1;
          end
        end
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_drive = 1'b1;
    step();
    rst_drive = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    valid_pct = 100; full_pct = 0; force_full = 1'b0; gate_mask = '0;
    while ((pending() || m_owner >= 0) && n < bound) begin
      step();
      n++;
    end
    step();
    check("drain_in_bound", 32'(n < bound), 32'd1);
  endtask

  initial begin
    int start;
    int exp_t2[10];
    rst = 1'b1; req_valid_i = '0; req_data_i = '0; req_last_i = '0; fifo_full_i = 1'b0;
    @(posedge clk);
    #1;
    rst_drive = 1'b1;
    run(2);
    rst_drive = 1'b0;
    run(1);
    check("rst_grant", 32'(s_grant), 32'h0);
    check("rst_busy", 32'(s_busy), 32'h0);
    check("rst_ready", 32'(s_ready), 32'h0);
    check("rst_we", 32'(s_we), 32'h0);

    // single 3-byte packet from requester 0
    clear_logs();
    push_pkt(0, 3, 8'h41, 1'b1);
    start = cyc;
    run(6);
    check("t1_nwr", 32'(wr_log.size()), 32'd3);
    check("t1_b0", 32'(wr_log[0]), 32'h041);
    check("t1_b1", 32'(wr_log[1]), 32'h042);
    check("t1_b2", 32'(wr_log[2]), 32'h043);
    check("t1_latency", 32'(wr_cyc[0] - start), 32'd2);
    check("t1_back2back", 32'(wr_cyc[2] - wr_cyc[0]), 32'd2);
    check("t1_grant", 32'(grant_log[0]), 32'd0);
    check("t1_busy_end", 32'(s_busy), 32'd0);

    // round robin across all four requesters
    do_reset();
    clear_logs();
    push_pkt(0, 2, 8'h00, 1'b1);
    push_pkt(1, 2, 8'h10, 1'b1);
    push_pkt(2, 2, 8'h20, 1'b1);
    push_pkt(3, 2, 8'h30, 1'b1);
    push_pkt(0, 2, 8'h02, 1'b1);
    drain(200);
    exp_t2 = '{32'h000, 32'h001, 32'h110, 32'h111, 32'h220, 32'h221,
               32'h330, 32'h331, 32'h002, 32'h003};
    check("t2_ngrant", 32'(grant_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) check("t2_order", 32'(grant_log[i]), 32'(i % NREQ));
    for (int i = 0; i < 10; i++) check("t2_bytes", 32'(wr_log[i]), 32'(exp_t2[i]));

    // burst limit forces release after 16 bytes
    do_reset();
    clear_logs();
    push_pkt(2, 20, 8'h80, 1'b1);
    run(2);
    push_pkt(3, 1, 8'h33, 1'b1);
    push_pkt(0, 1, 8'h0A, 1'b1);
    drain(300);
    check("t3_nwr", 32'(wr_log.size()), 32'd22);
    check("t3_16th", 32'(wr_log[15]), 32'h28F);
    check("t3_next3", 32'(wr_log[16]), 32'h333);
    check("t3_next0", 32'(wr_log[17]), 32'h00A);
    check("t3_resume", 32'(wr_log[18]), 32'h290);
    check("t3_tail", 32'(wr_log[21]), 32'h293);
    check("t3_g1", 32'(grant_log[1]), 32'd3);
    check("t3_g3", 32'(grant_log[3]), 32'd2);

    // FIFO full for 5 cycles mid-packet
    do_reset();
    clear_logs();
    push_pkt(1, 6, 8'hC0, 1'b1);
    run(3);
    force_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_ready_full", 32'(s_ready), 32'h0);
      check("t4_we_full", 32'(s_we), 32'h0);
      check("t4_grant_held", 32'(s_grant), 32'h2);
    end
    force_full = 1'b0;
    drain(200);
    check("t4_nwr", 32'(wr_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) check("t4_bytes", 32'(wr_log[i]), 32'(32'h1C0 + i));

    // reset mid-packet
    do_reset();
    clear_logs();
    push_pkt(1, 5, 8'hD0, 1'b1);
    run(3);
    push_pkt(0, 1, 8'hE0, 1'b1);
    do_reset();
    step();
    check("t5_grant0", 32'(s_grant), 32'h0);
    check("t5_busy0", 32'(s_busy), 32'h0);
    check("t5_ready0", 32'(s_ready), 32'h0);
    check("t5_we0", 32'(s_we), 32'h0);
    check("t5_wdata0", 32'(s_wdata), 32'h0);
    check("t5_timeout0", 32'(s_timeout), 32'h0);
    drain(200);
    check("t5_regrant", 32'(grant_log[1]), 32'd0);
    check("t5_nwr", 32'(wr_log.size()), 32'd6);
    check("t5_w2", 32'(wr_log[2]), 32'h0E0);
    check("t5_w3", 32'(wr_log[3]), 32'h1D2);
    check("t5_w5", 32'(wr_log[5]), 32'h1D4);

    // owner goes quiet mid-packet for 100 cycles
    do_reset();
    clear_logs();
    push_pkt(3, 2, 8'hF0, 1'b0);
    run(3);
    push_pkt(0, 1, 8'h01, 1'b1);
    run(100);
`ifdef UART_ARB_TIMEOUT_EN
    check("t6_pulses", 32'(tpulse_cnt), 32'd1);
    check("t6_next", 32'(grant_log[1]), 32'd0);
`else
    check("t6_pulses", 32'(tpulse_cnt), 32'd0);
    check("t6_held", 32'(s_grant), 32'h8);
    check("t6_busy", 32'(s_busy), 32'd1);
`endif
    push_pkt(3, 1, 8'hF2, 1'b1);
    drain(200);

    // randomized traffic with back-pressure
    do_reset();
    valid_pct = 70;
    full_pct = 20;
    for (int i = 0; i < 3000; i++) begin
      int k;
      k = int'($urandom_range(NREQ - 1));
      if ($urandom_range(3) == 0 && src_q[IW'(k)].size() < 40)
        push_pkt(k, int'($urandom_range(1, 20)), int'($urandom_range(255)), 1'b1);
      step();
    end
    drain(3000);
    check("all_bytes_written", 32'(written_total), 32'(pushed_total));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
